// File: rtl/mmu_array.sv
// mmu_array: NxN output-stationary systolic tile computing C = A x B.
// Column k of A and row k of B arrive together as one beat. Each row of A
// and each column of B is skewed so that matching operands meet in every PE.
// After the last beat the array is flushed, then result rows drain one per
// handshake.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no tile in flight, accumulators are zero, waiting for a beat
// S_COMPUTE | tile in progress, accepting beats until in_last
// S_FLUSH   | 2N-1 cycles letting skewed data reach the far corner PE
// S_DRAIN   | offering result rows 0..N-1 on out_row
module mmu_array #(
  parameter int N      = 2,
  parameter int DW     = 8,
  parameter int AW     = 2*DW+4,
  parameter int SIGNED = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DW-1:0]        a_in,
  input  logic [N*DW-1:0]        b_in,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*AW-1:0]        out_row,
  output logic [$clog2(N)-1:0]   out_idx,
  output logic                   busy
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(2*N);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_FLUSH, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic            accept;
  logic            drain_done;
  logic [CW-1:0]   flush_cnt_q;
  logic [IW-1:0]   row_q;

  logic [N-1:0][DW-1:0]         a_edge, b_edge;
  logic [N-1:0][DW-1:0]         a_ent, b_ent;
  logic [N-1:0][N-1:0][DW-1:0]  a_pe, b_pe;
  logic [N-1:0][N-1:0][AW-1:0]  acc_pe;

  // Operands are extended to AW before multiplying; the low AW bits of that
  // product equal the true product modulo 2^AW.
  function automatic logic [AW-1:0] mul_ext(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [AW-1:0] xe, ye;
    if (SIGNED != 0) begin
      xe = {{(AW-DW){x[DW-1]}}, x};
      ye = {{(AW-DW){y[DW-1]}}, y};
    end else begin
      xe = {{(AW-DW){1'b0}}, x};
      ye = {{(AW-DW){1'b0}}, y};
    end
    return xe * ye;
  endfunction

  assign in_ready   = (state_q == S_IDLE) || (state_q == S_COMPUTE);
  assign accept     = in_valid && in_ready;
  assign drain_done = (state_q == S_DRAIN) && out_ready && (row_q == IW'(N-1));

  // Zeros enter the edge on every cycle without an accepted beat.
  assign a_edge = accept ? a_in : '0;
  assign b_edge = accept ? b_in : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) state_d = in_last ? S_FLUSH : S_COMPUTE;
      end
      S_COMPUTE: if (accept && in_last) state_d = S_FLUSH;
      S_FLUSH:   if (flush_cnt_q == '0) state_d = S_DRAIN;
      S_DRAIN: begin
        out_valid = 1'b1;
        if (drain_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Flush timer: loaded with 2N-2 on entry, leaves FLUSH at terminal count zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        flush_cnt_q <= '0;
    else if (state_q != S_FLUSH && state_d == S_FLUSH) flush_cnt_q <= CW'(2*N-2);
    else if (state_q == S_FLUSH && flush_cnt_q != '0)  flush_cnt_q <= flush_cnt_q - CW'(1);
  end

  // Drain row pointer, advanced on each result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               row_q <= '0;
    else if (state_q == S_DRAIN && out_ready) row_q <= drain_done ? '0 : row_q + IW'(1);
  end

  assign out_idx = row_q;
  assign out_row = out_valid ? acc_pe[row_q] : '0;

  genvar gi, gj;

  // Input skew: row i of A and column i of B see an i-deep delay line.
  for (gi = 0; gi < N; gi++) begin : g_skew
    if (gi == 0) begin : g_direct
      assign a_ent[gi] = a_edge[gi];
      assign b_ent[gi] = b_edge[gi];
    end else begin : g_delay
      logic [gi-1:0][DW-1:0] a_sr, b_sr;
      // Shift one stage per cycle; cleared when a tile finishes draining.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_sr <= '0;
          b_sr <= '0;
        end else if (drain_done) begin
          a_sr <= '0;
          b_sr <= '0;
        end else begin
          for (int k = gi-1; k > 0; k--) begin
            a_sr[k] <= a_sr[k-1];
            b_sr[k] <= b_sr[k-1];
          end
          a_sr[0] <= a_edge[gi];
          b_sr[0] <= b_edge[gi];
        end
      end
      assign a_ent[gi] = a_sr[gi-1];
      assign b_ent[gi] = b_sr[gi-1];
    end
  end

  // PE grid: A moves right, B moves down, each PE accumulates its operand pair.
  for (gi = 0; gi < N; gi++) begin : g_row
    for (gj = 0; gj < N; gj++) begin : g_col
      logic [DW-1:0] a_nxt, b_nxt, a_q, b_q;
      logic [AW-1:0] acc_q;

      if (gj == 0) begin : g_a_edge
        assign a_nxt = a_ent[gi];
      end else begin : g_a_pass
        assign a_nxt = a_pe[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign b_nxt = b_ent[gj];
      end else begin : g_b_pass
        assign b_nxt = b_pe[gi-1][gj];
      end

      // Operand pass-through and multiply-accumulate, wrapping modulo 2^AW.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else if (drain_done) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else begin
          a_q   <= a_nxt;
          b_q   <= b_nxt;
          acc_q <= acc_q + mul_ext(a_pe[gi][gj], b_pe[gi][gj]);
        end
      end

      assign a_pe[gi][gj]   = a_q;
      assign b_pe[gi][gj]   = b_q;
      assign acc_pe[gi][gj] = acc_q;
    end
  end

endmodule

// File: tb/tb_mmu_array.sv
// tb_mmu_array: three 2x2 instances (unsigned AW=20, signed AW=20,
// unsigned AW=16) share one stimulus stream and are checked each cycle
// against a matrix-level reference model.
module tb_mmu_array;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;

  logic        ir [3];
  logic        ov [3];
  logic        bz [3];
  logic [0:0]  idx [3];
  logic [39:0] row0, row1;
  logic [31:0] row2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mmu_array #(.N(2), .DW(8), .AW(20), .SIGNED(0)) u_base (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .a_in(a_in), .b_in(b_in), .in_last(in_last), .out_valid(ov[0]),
    .out_ready(out_ready), .out_row(row0), .out_idx(idx[0]), .busy(bz[0]));

  mmu_array #(.N(2), .DW(8), .AW(20), .SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .a_in(a_in), .b_in(b_in), .in_last(in_last), .out_valid(ov[1]),
    .out_ready(out_ready), .out_row(row1), .out_idx(idx[1]), .busy(bz[1]));

  mmu_array #(.N(2), .DW(8), .AW(16), .SIGNED(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .a_in(a_in), .b_in(b_in), .in_last(in_last), .out_valid(ov[2]),
    .out_ready(out_ready), .out_row(row2), .out_idx(idx[2]), .busy(bz[2]));

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint dut_el(input int c, input int j);
    case (c)
      0:       return longint'(row0[j*20 +: 20]);
      1:       return longint'(row1[j*20 +: 20]);
      default: return longint'(row2[j*16 +: 16]);
    endcase
  endfunction

  function automatic longint mask_of(input int c);
    return (longint'(1) << ((c == 2) ? 16 : 20)) - 1;
  endfunction

  function automatic longint ext(input logic [7:0] v, input bit s);
    return s ? longint'($signed(v)) : longint'(v);
  endfunction

  // Reference model: the tile is a list of (column of A, row of B) beats;
  // C is the plain sum of outer products, reduced modulo 2^AW on compare.
  localparam int M_ACC   = 0;
  localparam int M_WAIT  = 1;
  localparam int M_DRAIN = 2;

  int     mode = M_ACC;
  int     beats = 0;
  int     wait_cnt = 0;
  int     mrow = 0;
  int     cyc = 0;
  int     last_cyc = 0;
  int     lat = -1;
  bit     ov_seen = 1'b1;
  int     tiles_done = 0;
  longint macc [3][2][2];
  longint cap  [3][2][2];

  task automatic model_clear();
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          macc[c][i][j] = 0;
  endtask

  initial model_clear();

  // Compare DUT outputs with the model mid-cycle, then advance the model by
  // the handshakes that the coming rising edge will take.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("rst_in_ready[%0d]", c), longint'(ir[c]), 1);
        chk($sformatf("rst_out_valid[%0d]", c), longint'(ov[c]), 0);
        chk($sformatf("rst_busy[%0d]", c), longint'(bz[c]), 0);
        chk($sformatf("rst_out_idx[%0d]", c), longint'(idx[c]), 0);
        for (int j = 0; j < N; j++)
          chk($sformatf("rst_out_row[%0d][%0d]", c, j), dut_el(c, j), 0);
      end
      mode = M_ACC; beats = 0; mrow = 0; wait_cnt = 0;
      model_clear();
    end else begin
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("in_ready[%0d]", c), longint'(ir[c]), longint'(mode == M_ACC));
        chk($sformatf("busy[%0d]", c), longint'(bz[c]), longint'(!(mode == M_ACC && beats == 0)));
        chk($sformatf("out_valid[%0d]", c), longint'(ov[c]), longint'(mode == M_DRAIN));
        if (mode == M_DRAIN) begin
          chk($sformatf("out_idx[%0d]", c), longint'(idx[c]), longint'(mrow));
          for (int j = 0; j < N; j++)
            chk($sformatf("out_row[%0d] r%0d c%0d", c, mrow, j), dut_el(c, j),
                macc[c][mrow][j] & mask_of(c));
        end
      end
      if (ov[0] && !ov_seen) begin
        ov_seen = 1'b1;
        lat = cyc - last_cyc;
      end
      case (mode)
        M_ACC: if (in_valid) begin
          for (int c = 0; c < 3; c++)
            for (int i = 0; i < N; i++)
              for (int j = 0; j < N; j++)
                macc[c][i][j] += ext(a_in[i*8 +: 8], c == 1) * ext(b_in[j*8 +: 8], c == 1);
          beats++;
          if (in_last) begin
            mode = M_WAIT; wait_cnt = 2*N-1; last_cyc = cyc; ov_seen = 1'b0;
          end
        end
        M_WAIT: begin
          wait_cnt--;
          if (wait_cnt == 0) mode = M_DRAIN;
        end
        default: if (out_ready) begin
          for (int c = 0; c < 3; c++)
            for (int j = 0; j < N; j++)
              cap[c][mrow][j] = dut_el(c, j);
          if (mrow == N-1) begin
            mode = M_ACC; beats = 0; mrow = 0; tiles_done++;
            model_clear();
          end else begin
            mrow++;
          end
        end
      endcase
    end
  end

  task automatic drive(input logic [7:0] a0, a1, b0, b1, input bit v, input bit last);
    in_valid = v; in_last = last;
    a_in = {a1, a0}; b_in = {b1, b0};
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; a_in = '0; b_in = '0;
  endtask

  task automatic wait_tile(input string nm);
    int start;
    int n;
    start = tiles_done;
    n = 0;
    while (tiles_done == start && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_tile_done"}, longint'(tiles_done != start), 1);
  endtask

  task automatic chk_rows(input string nm, input int c, input longint e00, e01, e10, e11);
    chk({nm, "_r0c0"}, cap[c][0][0], e00);
    chk({nm, "_r0c1"}, cap[c][0][1], e01);
    chk({nm, "_r1c0"}, cap[c][1][0], e10);
    chk({nm, "_r1c1"}, cap[c][1][1], e11);
  endtask

  task automatic basic_tile();
    drive(8'd1, 8'd3, 8'd5, 8'd6, 1'b1, 1'b0);
    drive(8'd2, 8'd4, 8'd7, 8'd8, 1'b1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    drive(8'd9, 8'd9, 8'd9, 8'd9, 1'b0, 1'b1);   // in_last without in_valid is ignored

    basic_tile();
    wait_tile("basic");
    chk_rows("basic", 0, 19, 22, 43, 50);
    chk("basic_latency", longint'(lat), 4);

    drive(8'd1, 8'd3, 8'd5, 8'd6, 1'b1, 1'b0);
    drive(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    drive(8'd77, 8'd66, 8'd55, 8'd44, 1'b0, 1'b1);
    drive(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    drive(8'd2, 8'd4, 8'd7, 8'd8, 1'b1, 1'b1);
    wait_tile("bubbles");
    chk_rows("bubbles", 0, 19, 22, 43, 50);

    drive(8'hFF, 8'h00, 8'h02, 8'h00, 1'b1, 1'b0);
    drive(8'h00, 8'hFF, 8'h00, 8'h03, 1'b1, 1'b1);
    wait_tile("signed");
    chk_rows("signed", 1, 64'hFFFFE, 0, 0, 64'hFFFFD);

    drive(8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 1'b0);
    drive(8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 1'b1);
    wait_tile("wrap");
    chk_rows("wrap", 2, 64514, 64514, 64514, 64514);

    out_ready = 1'b0;
    basic_tile();
    begin
      int n;
      n = 0;
      while (!ov[0] && n < 20) begin
        in_valid = 1'b1; in_last = 1'($urandom_range(0, 1));
        a_in = 16'($urandom); b_in = 16'($urandom);
        @(posedge clk); #1;
        n++;
      end
    end
    chk("bp_reached_drain", longint'(ov[0]), 1);
    repeat (5) begin
      in_valid = 1'b1; a_in = 16'($urandom); b_in = 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; a_in = '0; b_in = '0;
    out_ready = 1'b1;
    wait_tile("bp");
    chk_rows("bp", 0, 19, 22, 43, 50);
    chk("bp_latency", longint'(lat), 4);

    drive(8'd2, 8'd3, 8'd4, 8'd5, 1'b1, 1'b1);
    wait_tile("single");
    chk_rows("single", 0, 8, 10, 12, 15);

    drive(8'd9, 8'd9, 8'd9, 8'd9, 1'b1, 1'b0);
    drive(8'd7, 8'd7, 8'd7, 8'd7, 1'b1, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    basic_tile();
    wait_tile("rst_mid");
    chk_rows("rst_mid", 0, 19, 22, 43, 50);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
